// File: rtl/aes_stream_loader.sv
// aes_stream_loader
//   Streaming wrapper around the combinational aes_main core.
//   Collects four 32-bit words into a 128-bit key or plaintext block. Drives the
//   core inputs and keeps them stable for SETTLE_CYCLES edges, because the core
//   is one long combinational path. It then captures the ciphertext and sends
//   it back out as four 32-bit words over a valid/ready handshake.
//
// Parameters
//   SETTLE_CYCLES  edges the core inputs are held before data_out is sampled (1..15)
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_data  32-bit word input stream
//   in_is_key                  1 = word belongs to key group, 0 = plaintext group
//   out_valid/out_ready        ciphertext word handshake
//   out_data/out_last          ciphertext word, last flag on the 4th word
//   err_nokey                  1-cycle pulse, plaintext block dropped (no key loaded)
//   core_data_in/core_key      to aes_main
//   core_data_out              from aes_main
//
// Word order is big-endian by word. Word 0 occupies [127:96].

// One 32-bit lane of the shadow (assembly) register.
module aes_stream_loader_lane #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module aes_stream_loader #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_is_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         err_nokey,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key,
  input  logic [127:0] core_data_out
);

  localparam int          NUM_WORDS   = 4;
  localparam int          WORD_W      = 32;
  localparam logic [1:0]  LAST_IDX    = 2'(NUM_WORDS - 1);
  localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {LOAD, SETTLE, SEND} state_t;

  state_t state;

  // Element NUM_WORDS-1 is word 0, i.e. bits [127:96].
  logic [NUM_WORDS-1:0][WORD_W-1:0] shadow;
  logic [NUM_WORDS-1:0][WORD_W-1:0] blk;
  logic [NUM_WORDS-1:0][WORD_W-1:0] result;
  logic [NUM_WORDS-1:0]             lane_we;

  logic [1:0] wcnt;        // words held in the partial group
  logic       grp_key;     // type of the partial group
  logic       key_loaded;
  logic [3:0] scnt;        // settle countdown
  logic [1:0] ocnt;        // index of the word currently on out_data
  logic [1:0] idx;         // slot the incoming word lands in
  logic [1:0] nxt;
  logic       take;

  // in_ready is only ever 1 in LOAD, so a transfer implies LOAD.
  assign take = in_valid & in_ready;

  // A word of the other group type restarts assembly at slot 0; the
  // partial group is silently discarded.
  assign idx = (wcnt != 2'd0 && grp_key != in_is_key) ? 2'd0 : wcnt;
  assign nxt = ocnt + 2'd1;

  // Full block as it will look once the 4th word is written.
  always_comb begin
    blk    = shadow;
    blk[0] = in_data;
  end

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_lane
    assign lane_we[i] = take && (idx == 2'(NUM_WORDS - 1 - i));
    aes_stream_loader_lane #(.WORD_W(WORD_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_we[i]),
      .d     (in_data),
      .q     (shadow[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      err_nokey    <= 1'b0;
      core_data_in <= '0;
      core_key     <= '0;
      result       <= '0;
      key_loaded   <= 1'b0;
      wcnt         <= '0;
      grp_key      <= 1'b0;
      scnt         <= '0;
      ocnt         <= '0;
    end else begin
      err_nokey <= 1'b0;
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (take) begin
            grp_key <= in_is_key;
            if (idx == LAST_IDX) begin
              wcnt <= '0;
              if (in_is_key) begin
                core_key   <= blk;
                key_loaded <= 1'b1;
              end else if (key_loaded) begin
                core_data_in <= blk;
                scnt         <= SETTLE_INIT;
                in_ready     <= 1'b0;
                state        <= SETTLE;
              end else begin
                err_nokey <= 1'b1;
              end
            end else begin
              wcnt <= idx + 2'd1;
            end
          end
        end

        // Core inputs are frozen here; data_out is sampled on the last edge.
        SETTLE: begin
          scnt <= scnt - 4'd1;
          if (scnt == 4'd1) begin
            result    <= core_data_out;
            out_data  <= core_data_out[127:96];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            ocnt      <= '0;
            state     <= SEND;
          end
        end

        // out_valid is always 1 in SEND, so out_ready alone completes a beat.
        SEND: begin
          if (out_ready) begin
            if (ocnt == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= LOAD;
            end else begin
              ocnt     <= nxt;
              out_data <= result[LAST_IDX - nxt];
              out_last <= (nxt == LAST_IDX);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule
